// File: rtl/hello_scroller.sv
// hello_scroller: shifts the message "HELLO" plus three blanks across six
// active-low seven-segment digits. One display step is taken for every
// TICK_DIV qualifying upstream ticks. The FSM first fills the display (FILL)
// and then keeps scrolling (SCROLL) until it is restarted or reset.
module hello_scroller #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clk_en,
   input  logic       tick,
   input  logic       start,
   input  logic       pause,
   output logic [6:0] hex5,
   output logic [6:0] hex4,
   output logic [6:0] hex3,
   output logic [6:0] hex2,
   output logic [6:0] hex1,
   output logic [6:0] hex0,
   output logic       scrolling,
   output logic       msg_wrap
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      SCROLL = 2'd2
   } state_t;

   // Character codes held in the display registers
   localparam logic [2:0] CH_H     = 3'd0;
   localparam logic [2:0] CH_E     = 3'd1;
   localparam logic [2:0] CH_L     = 3'd2;
   localparam logic [2:0] CH_O     = 3'd3;
   localparam logic [2:0] CH_BLANK = 3'd4;

   // Divider terminal count: the step happens on the tick where div hits it
   localparam logic [3:0] DIV_LAST = 4'(TICK_DIV - 1);
   // The eighth step of FILL is the one taken while fill_cnt is 7
   localparam logic [3:0] FILL_LAST = 4'd7;

   // Message ROM: H E L L O followed by three blanks
   function automatic logic [2:0] msg_char(input logic [2:0] idx);
      logic [2:0] c;
      case (idx)
         3'd0:    c = CH_H;
         3'd1:    c = CH_E;
         3'd2:    c = CH_L;
         3'd3:    c = CH_L;
         3'd4:    c = CH_O;
         default: c = CH_BLANK;
      endcase
      return c;
   endfunction

   // Active-low {g,f,e,d,c,b,a}; any unused code shows blank
   function automatic logic [6:0] seg_decode(input logic [2:0] code);
      logic [6:0] s;
      case (code)
         CH_H:    s = 7'h09;
         CH_E:    s = 7'h06;
         CH_L:    s = 7'h47;
         CH_O:    s = 7'h40;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   state_t          state;
   state_t          state_next;
   logic [5:0][2:0] disp;       // disp[5] is the leftmost digit
   logic [2:0]      ptr;
   logic [3:0]      div;
   logic [3:0]      fill_cnt;
   logic            qual;
   logic            step;
   logic            restart;

   // Qualify ticks, detect steps and restarts, and pick the next FSM state
   always_comb begin
      state_next = state;
      qual       = clk_en && tick && !pause && (state != IDLE);
      step       = qual && (div == DIV_LAST);
      restart    = clk_en && !pause && start;
      case (state)
         IDLE: begin
            if (restart) state_next = FILL;
            else         state_next = IDLE;
         end
         FILL: begin
            if (restart)                             state_next = FILL;
            else if (step && (fill_cnt == FILL_LAST)) state_next = SCROLL;
            else                                     state_next = FILL;
         end
         SCROLL: begin
            if (restart) state_next = FILL;
            else         state_next = SCROLL;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Display shift register, message pointer, tick divider and fill counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         disp     <= {6{CH_BLANK}};
         ptr      <= 3'd0;
         div      <= 4'd0;
         fill_cnt <= 4'd0;
      end else if (restart) begin
         // Restart wins over a step arriving in the same cycle
         disp     <= {6{CH_BLANK}};
         ptr      <= 3'd0;
         div      <= 4'd0;
         fill_cnt <= 4'd0;
      end else if (step) begin
         disp <= {disp[4:0], msg_char(ptr)};
         ptr  <= ptr + 3'd1;
         div  <= 4'd0;
         if (state == FILL) fill_cnt <= fill_cnt + 4'd1;
         else               fill_cnt <= fill_cnt;
      end else if (qual) begin
         div <= div + 4'd1;
      end else begin
         // Paused, disabled or idle: everything holds
         disp     <= disp;
         ptr      <= ptr;
         div      <= div;
         fill_cnt <= fill_cnt;
      end
   end

   // One-cycle pulse after the step that wraps the pointer from 7 to 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) msg_wrap <= 1'b0;
      else          msg_wrap <= step && !restart && (ptr == 3'd7);
   end

   assign scrolling = (state == SCROLL);

   assign hex5 = seg_decode(disp[5]);
   assign hex4 = seg_decode(disp[4]);
   assign hex3 = seg_decode(disp[3]);
   assign hex2 = seg_decode(disp[2]);
   assign hex1 = seg_decode(disp[1]);
   assign hex0 = seg_decode(disp[0]);

endmodule

// File: tb/tb_hello_scroller.sv
// Directed bench for hello_scroller: one instance with TICK_DIV=1 and one
// with TICK_DIV=3, both driven by the same stimulus.
module tb_hello_scroller;

   logic       clk;
   logic       reset_n;
   logic       clk_en;
   logic       tick;
   logic       start;
   logic       pause;
   logic [6:0] a5, a4, a3, a2, a1, a0;
   logic [6:0] b5, b4, b3, b2, b1, b0;
   logic       a_scrolling, a_wrap, b_scrolling, b_wrap;

   int checks = 0;
   int errors = 0;

   localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

   hello_scroller #(.TICK_DIV(1)) dut (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .tick(tick),
      .start(start), .pause(pause),
      .hex5(a5), .hex4(a4), .hex3(a3), .hex2(a2), .hex1(a1), .hex0(a0),
      .scrolling(a_scrolling), .msg_wrap(a_wrap)
   );

   hello_scroller #(.TICK_DIV(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .tick(tick),
      .start(start), .pause(pause),
      .hex5(b5), .hex4(b4), .hex3(b3), .hex2(b2), .hex1(b1), .hex0(b0),
      .scrolling(b_scrolling), .msg_wrap(b_wrap)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic check(input string tag, input logic [41:0] actual,
                        input logic [41:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // One-cycle tick pulse; returns on the falling edge after the step edge
   task automatic pulse_tick();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [41:0] disp_a();
      return {a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic logic [41:0] disp_b();
      return {b5, b4, b3, b2, b1, b0};
   endfunction

   initial begin
      reset_n = 1'b0;
      clk_en  = 1'b1;
      tick    = 1'b0;
      start   = 1'b0;
      pause   = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("reset_display", disp_a(), ALL_BLANK);
      check("reset_scrolling", 42'(a_scrolling), 42'd0);
      check("reset_wrap", 42'(a_wrap), 42'd0);
      reset_n = 1'b1;

      // Ticks in IDLE are ignored
      pulse_tick();
      check("idle_tick", disp_a(), ALL_BLANK);

      pulse_start();
      check("start_blank", disp_a(), ALL_BLANK);
      check("start_not_scrolling", 42'(a_scrolling), 42'd0);

      pulse_tick();
      check("fill_1", disp_a(), {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h09});
      repeat (5) pulse_tick();
      check("fill_6", disp_a(), {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F});
      check("fill_6_scrolling", 42'(a_scrolling), 42'd0);

      pulse_tick();
      check("tick7_wrap", 42'(a_wrap), 42'd0);
      check("tick7_scrolling", 42'(a_scrolling), 42'd0);
      pulse_tick();
      check("tick8_scrolling", 42'(a_scrolling), 42'd1);
      check("tick8_wrap", 42'(a_wrap), 42'd1);
      check("tick8_display", disp_a(), {7'h47, 7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F});
      @(negedge clk);
      check("wrap_one_cycle", 42'(a_wrap), 42'd0);

      // Pause discards ticks; one tick after release advances one position
      pause = 1'b1;
      repeat (3) pulse_tick();
      check("paused_display", disp_a(), {7'h47, 7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F});
      pause = 1'b0;
      pulse_tick();
      check("after_pause", disp_a(), {7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h09});

      // clk_en low holds everything
      clk_en = 1'b0;
      pulse_tick();
      check("clk_en_low", disp_a(), {7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h09});
      clk_en = 1'b1;

      // Start and tick together in SCROLL: restart wins, no shift
      @(negedge clk);
      start = 1'b1;
      tick  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tick  = 1'b0;
      check("restart_blank", disp_a(), ALL_BLANK);
      check("restart_scrolling", 42'(a_scrolling), 42'd0);
      pulse_tick();
      check("restart_ptr0", disp_a(), {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h09});

      // Divide-by-three instance: 5 ticks give one step, the 6th a second
      pulse_start();
      repeat (5) pulse_tick();
      check("div3_5ticks", disp_b(), {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h09});
      pulse_tick();
      check("div3_6ticks", disp_b(), {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h09, 7'h06});
      check("div1_6ticks", disp_a(), {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F});

      // Bring the divide-by-one instance into SCROLL, then reset mid-cycle
      repeat (2) pulse_tick();
      check("scroll_before_reset", 42'(a_scrolling), 42'd1);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_display", disp_a(), ALL_BLANK);
      check("async_reset_scrolling", 42'(a_scrolling), 42'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) pulse_tick();
      check("post_reset_ticks", disp_a(), ALL_BLANK);
      check("post_reset_idle", 42'(a_scrolling), 42'd0);
      pulse_start();
      pulse_tick();
      check("post_reset_restart", disp_a(), {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h09});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
